// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record layout, flag positions and FSM states.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTED  = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } trace_state_e;

   // Flag nibble sits in the top bits of every record.
   localparam int REC_FLAG_W = 4;
   localparam int FLAG_HALT  = 3;
   localparam int FLAG_WE    = 2;
   localparam int FLAG_LD    = 1;
   localparam int FLAG_ST    = 0;

   typedef struct packed {
      logic        halt;
      logic        reg_we;
      logic        ld;
      logic        st;
      logic [3:0]  reg_idx;
      logic [15:0] reg_data;
      logic [15:0] mem_addr;
      logic [15:0] mem_data;
   } trace_rec_t;

   localparam int REC_W = $bits(trace_rec_t);

   function automatic int rec_width(input int reg_w, input int data_w, input int addr_w);
      return REC_FLAG_W + reg_w + data_w + addr_w + data_w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record FIFO; a push into a full FIFO only lands when a pop frees a slot the same cycle.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int WIDTH = REC_W,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic             one_left,
   output logic [WIDTH-1:0] rdata
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             push_ok_s, pop_ok_s;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == (PTR_W+1)'(0));
   assign one_left  = (count_q == (PTR_W+1)'(1));
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);
   assign rdata     = mem_q[rd_ptr_q];

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // pointers wrap naturally at DEPTH because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture with counters and run/halt FSM.
// Watchdog and TIMEOUT state exist only when COMMIT_TRACE_TIMEOUT_EN is defined.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int REG_W   = 4,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 100000,
   localparam int EV_REC_W = rec_width(REG_W, DATA_W, ADDR_W)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                trace_en,
   input  logic                halt,
   input  logic                reg_we,
   input  logic [REG_W-1:0]    reg_idx,
   input  logic [DATA_W-1:0]   reg_data,
   input  logic                mem_en,
   input  logic                mem_wr,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                ev_ready,
   output logic                ev_valid,
   output logic [EV_REC_W-1:0] ev_rec,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    inst_cnt,
   output logic [CNT_W-1:0]    drop_cnt,
   output logic                overflow,
   output logic                done,
   output logic                timeout
);

   trace_state_e          state_q, state_d;
   logic [CNT_W-1:0]      cycle_cnt_q, inst_cnt_q, drop_cnt_q;
   logic                  overflow_q;
   logic [REC_FLAG_W-1:0] flags_s;
   logic [EV_REC_W-1:0]   rec_s;
   logic                  capture_s, pop_s, drop_s, to_hit_s, drain_empty_s;
   logic                  full_s, empty_s, one_left_s;
   logic                  inst_inc_s, cyc_inc_s;

   assign capture_s     = (state_q == ST_RUN) & trace_en & (halt | reg_we | mem_en);
   assign pop_s         = ev_ready & ~empty_s;
   assign drop_s        = capture_s & full_s & ~pop_s;
   assign drain_empty_s = empty_s | (one_left_s & pop_s);
   assign inst_inc_s    = (state_q == ST_RUN) & (halt | reg_we | (mem_en & mem_wr));
   assign cyc_inc_s     = (state_q == ST_RUN) | (state_q == ST_HALTED);

`ifdef COMMIT_TRACE_TIMEOUT_EN
   assign to_hit_s = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
   assign timeout  = (state_q == ST_TIMEOUT);
`else
   assign to_hit_s = 1'b0;
   assign timeout  = 1'b0;
`endif

   // record assembly; fields of events that did not happen are forced to zero
   always_comb begin
      flags_s            = '0;
      flags_s[FLAG_HALT] = halt;
      flags_s[FLAG_WE]   = reg_we;
      flags_s[FLAG_LD]   = mem_en & ~mem_wr;
      flags_s[FLAG_ST]   = mem_en & mem_wr;
      rec_s = {flags_s,
               reg_we ? reg_idx  : {REG_W{1'b0}},
               reg_we ? reg_data : {DATA_W{1'b0}},
               mem_en ? mem_addr : {ADDR_W{1'b0}},
               mem_en ? (mem_wr ? mem_wdata : mem_rdata) : {DATA_W{1'b0}}};
   end

   // next-state logic; halt wins over a coincident watchdog expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (halt)          state_d = ST_HALTED;
            else if (to_hit_s) state_d = ST_TIMEOUT;
            else               state_d = ST_RUN;
         end
         ST_HALTED: begin
            if (drain_empty_s) state_d = ST_DONE;
            else               state_d = ST_HALTED;
         end
         ST_DONE:    state_d = ST_DONE;
         ST_TIMEOUT: state_d = ST_TIMEOUT;
         default:    state_d = ST_RUN;
      endcase
   end

   // state and saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cycle_cnt_q <= '0;
         inst_cnt_q  <= '0;
         drop_cnt_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cyc_inc_s && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (inst_inc_s && inst_cnt_q != '1) inst_cnt_q <= inst_cnt_q + CNT_W'(1);
         if (drop_s && drop_cnt_q != '1)     drop_cnt_q <= drop_cnt_q + CNT_W'(1);
         if (drop_s)                         overflow_q <= 1'b1;
      end
   end

   trace_fifo #(.WIDTH(EV_REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (capture_s),
      .pop      (pop_s),
      .wdata    (rec_s),
      .full     (full_s),
      .empty    (empty_s),
      .one_left (one_left_s),
      .rdata    (ev_rec)
   );

   assign ev_valid  = ~empty_s;
   assign cycle_cnt = cycle_cnt_q;
   assign inst_cnt  = inst_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign overflow  = overflow_q;
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: vector table, corner sequences, random vs queue model.
module tb_commit_trace_buffer;

`ifdef COMMIT_TRACE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO_LIM = 50;
   localparam int DEP    = 8;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        trace_en, halt, reg_we, mem_en, mem_wr, ev_ready;
   logic [3:0]  reg_idx;
   logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;
   logic        ev_valid, overflow, done, timeout;
   logic [55:0] ev_rec;
   logic [31:0] cycle_cnt, inst_cnt, drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   commit_trace_buffer #(.DEPTH(DEP), .TIMEOUT(TO_LIM)) dut (
      .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .halt(halt), .reg_we(reg_we),
      .reg_idx(reg_idx), .reg_data(reg_data), .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_rec(ev_rec), .cycle_cnt(cycle_cnt),
      .inst_cnt(inst_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .done(done),
      .timeout(timeout)
   );

   // behavioural model: 0 RUN, 1 HALTED, 2 DONE, 3 TIMEOUT
   logic [55:0] mq[$];
   int unsigned m_cyc, m_inst, m_drop;
   bit          m_ovf;
   int          m_st;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [55:0] mk_rec();
      return {halt, reg_we, mem_en & ~mem_wr, mem_en & mem_wr,
              reg_we ? reg_idx : 4'h0, reg_we ? reg_data : 16'h0,
              mem_en ? mem_addr : 16'h0, mem_en ? (mem_wr ? mem_wdata : mem_rdata) : 16'h0};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 1'b0; m_st = 0;
   endtask

   task automatic model_step();
      bit cap, was_full, popd;
      int nst;
      cap      = (m_st == 0) && trace_en && (halt || reg_we || mem_en);
      was_full = (mq.size() == DEP);
      popd     = (mq.size() > 0) && ev_ready;
      nst      = m_st;
      if (popd) void'(mq.pop_front());
      if (cap) begin
         if (!was_full || popd) mq.push_back(mk_rec());
         else begin
            if (m_drop != 32'hFFFF_FFFF) m_drop++;
            m_ovf = 1'b1;
         end
      end
      if (m_st == 0 && (halt || reg_we || (mem_en && mem_wr)) && m_inst != 32'hFFFF_FFFF) m_inst++;
      if ((m_st == 0 || m_st == 1) && m_cyc != 32'hFFFF_FFFF) begin
         if (m_st == 0 && !halt && TO_EN && m_cyc == TO_LIM - 1) nst = 3;
         m_cyc++;
      end
      if (m_st == 0 && halt) nst = 1;
      if (m_st == 1 && mq.size() == 0) nst = 2;
      m_st = nst;
   endtask

   task automatic idle();
      trace_en = 1'b1; halt = 1'b0; reg_we = 1'b0; mem_en = 1'b0; mem_wr = 1'b0;
      reg_idx = 4'h0; reg_data = 16'h0; mem_addr = 16'h0; mem_wdata = 16'h0;
      mem_rdata = 16'h0; ev_ready = 1'b0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wr_reg(input logic [3:0] idx, input logic [15:0] d);
      reg_we = 1'b1; reg_idx = idx; reg_data = d;
   endtask

   task automatic compare_all();
      chk("rnd_valid", {63'd0, ev_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) chk("rnd_rec", {8'd0, ev_rec}, {8'd0, mq[0]});
      chk("rnd_cycle", {32'd0, cycle_cnt}, {32'd0, m_cyc});
      chk("rnd_inst", {32'd0, inst_cnt}, {32'd0, m_inst});
      chk("rnd_drop", {32'd0, drop_cnt}, {32'd0, m_drop});
      chk("rnd_ovf", {63'd0, overflow}, {63'd0, m_ovf});
      chk("rnd_done", {63'd0, done}, {63'd0, m_st == 2});
      chk("rnd_timeout", {63'd0, timeout}, {63'd0, m_st == 3});
   endtask

   typedef struct {
      logic        te, hl, we;
      logic [3:0]  idx;
      logic [15:0] rd;
      logic        me, mw;
      logic [15:0] ad, wd, rdd;
      logic        exp_v;
      logic [55:0] exp_rec;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vt[7];

   initial begin
      idle();
      vt[0] = '{1'b1, 1'b0, 1'b1, 4'h3, 16'h00AB, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0,
                1'b1, {4'b0100, 4'h3, 16'h00AB, 16'h0000, 16'h0000}, 32'd1};
      vt[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'hDEAD,
                1'b1, {4'b0001, 4'h0, 16'h0000, 16'h0010, 16'h1234}, 32'd2};
      vt[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'hCAFE, 16'h5678,
                1'b1, {4'b0010, 4'h0, 16'h0000, 16'h0010, 16'h5678}, 32'd2};
      vt[3] = '{1'b1, 1'b0, 1'b1, 4'h5, 16'hBEEF, 1'b1, 1'b0, 16'h0100, 16'h7777, 16'h0042,
                1'b1, {4'b0110, 4'h5, 16'hBEEF, 16'h0100, 16'h0042}, 32'd3};
      vt[4] = '{1'b0, 1'b0, 1'b1, 4'h7, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0,
                1'b0, 56'd0, 32'd4};
      vt[5] = '{1'b1, 1'b0, 1'b0, 4'h9, 16'h2222, 1'b0, 1'b1, 16'h3333, 16'h4444, 16'h5555,
                1'b0, 56'd0, 32'd4};
      vt[6] = '{1'b1, 1'b0, 1'b1, 4'hF, 16'h1111, 1'b0, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC,
                1'b1, {4'b0100, 4'hF, 16'h1111, 16'h0000, 16'h0000}, 32'd5};

      // reset state
      do_reset();
      chk("rst_valid", {63'd0, ev_valid}, 64'd0);
      chk("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
      chk("rst_inst", {32'd0, inst_cnt}, 64'd0);
      chk("rst_drop", {32'd0, drop_cnt}, 64'd0);
      chk("rst_ovf", {63'd0, overflow}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_timeout", {63'd0, timeout}, 64'd0);

      // single-transaction vectors
      for (int i = 0; i < 7; i++) begin
         chk("vec_no_bypass", {63'd0, ev_valid}, 64'd0);
         trace_en = vt[i].te; halt = vt[i].hl; reg_we = vt[i].we; reg_idx = vt[i].idx;
         reg_data = vt[i].rd; mem_en = vt[i].me; mem_wr = vt[i].mw; mem_addr = vt[i].ad;
         mem_wdata = vt[i].wd; mem_rdata = vt[i].rdd; ev_ready = 1'b1;
         tick();
         chk($sformatf("vec%0d_valid", i), {63'd0, ev_valid}, {63'd0, vt[i].exp_v});
         if (vt[i].exp_v) chk($sformatf("vec%0d_rec", i), {8'd0, ev_rec}, {8'd0, vt[i].exp_rec});
         chk($sformatf("vec%0d_inst", i), {32'd0, inst_cnt}, {32'd0, vt[i].exp_inst});
         idle(); ev_ready = 1'b1;
         tick();
      end

      // overflow, hold stability, full push+pop, ordered drain
      do_reset();
      for (int i = 0; i < 10; i++) begin
         wr_reg(4'(i), 16'h0100 + 16'(i));
         tick();
      end
      idle();
      chk("ovf_drop", {32'd0, drop_cnt}, 64'd2);
      chk("ovf_flag", {63'd0, overflow}, 64'd1);
      chk("ovf_head", {48'd0, ev_rec[47:32]}, 64'h0100);
      tick();
      chk("hold_head", {48'd0, ev_rec[47:32]}, 64'h0100);
      wr_reg(4'hA, 16'h0200); ev_ready = 1'b1;
      tick();
      chk("fullpp_drop", {32'd0, drop_cnt}, 64'd2);
      idle(); ev_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d_valid", k), {63'd0, ev_valid}, 64'd1);
         chk($sformatf("drain%0d_data", k), {48'd0, ev_rec[47:32]},
             (k < 7) ? 64'h0101 + 64'(k) : 64'h0200);
         tick();
      end
      chk("drain_empty", {63'd0, ev_valid}, 64'd0);

      // halt with three queued records
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_reg(4'(i), 16'h0010 + 16'(i));
         tick();
      end
      reg_we = 1'b0; halt = 1'b1;
      tick();
      chk("halt_inst", {32'd0, inst_cnt}, 64'd4);
      halt = 1'b0; wr_reg(4'h9, 16'h9999); ev_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("hpop%0d_valid", k), {63'd0, ev_valid}, 64'd1);
         chk($sformatf("hpop%0d_rec", k), {8'd0, ev_rec},
             (k < 3) ? {8'd0, 4'b0100, 4'(k), 16'h0010 + 16'(k), 32'd0} : {8'd0, 4'b1000, 52'd0});
         chk($sformatf("hpop%0d_done", k), {63'd0, done}, 64'd0);
         tick();
      end
      chk("halt_done", {63'd0, done}, 64'd1);
      chk("halt_empty", {63'd0, ev_valid}, 64'd0);
      repeat (3) tick();
      chk("done_sticky", {63'd0, done}, 64'd1);
      chk("done_ignore", {63'd0, ev_valid}, 64'd0);
      chk("done_inst", {32'd0, inst_cnt}, 64'd4);
      chk("done_cycle", {32'd0, cycle_cnt}, {32'd0, m_cyc});

      // watchdog
      do_reset();
      repeat (TO_LIM - 1) tick();
      chk("to_pre_cycle", {32'd0, cycle_cnt}, 64'(TO_LIM - 1));
      chk("to_pre_flag", {63'd0, timeout}, 64'd0);
      tick();
      chk("to_flag", {63'd0, timeout}, {63'd0, TO_EN});
      chk("to_cycle", {32'd0, cycle_cnt}, 64'(TO_LIM));
      repeat (5) tick();
      chk("to_frozen", {32'd0, cycle_cnt}, TO_EN ? 64'(TO_LIM) : 64'(TO_LIM + 5));
      chk("to_sticky", {63'd0, timeout}, {63'd0, TO_EN});

      // asynchronous reset mid-run
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_reg(4'(i), 16'h0300 + 16'(i));
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, ev_valid}, 64'd0);
      chk("arst_cycle", {32'd0, cycle_cnt}, 64'd0);
      chk("arst_inst", {32'd0, inst_cnt}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      do_reset();
      tick();
      chk("arst_run", {32'd0, cycle_cnt}, 64'd1);
      chk("arst_novalid", {63'd0, ev_valid}, 64'd0);

      // randomized segments against the model
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         for (int c = 0; c < 70; c++) begin
            compare_all();
            trace_en  = ($urandom_range(0, 7) != 0);
            halt      = ($urandom_range(0, 63) == 0);
            reg_we    = $urandom_range(0, 1) == 1;
            reg_idx   = 4'($urandom());
            reg_data  = 16'($urandom());
            mem_en    = ($urandom_range(0, 9) < 4);
            mem_wr    = $urandom_range(0, 1) == 1;
            mem_addr  = 16'($urandom());
            mem_wdata = 16'($urandom());
            mem_rdata = 16'($urandom());
            ev_ready  = ($urandom_range(0, 2) == 0);
            tick();
         end
         compare_all();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
